// File: rtl/req_gnt_pkg.sv
// req_gnt_pkg: shared FSM state encoding and bus widths for the request/grant write master.
package req_gnt_pkg;
  localparam int AW = 8;
  localparam int DW = 8;
  typedef enum logic [2:0] {IDLE, REQ, DATA, WRITE, RELEASE} state_t;
endpackage

// File: rtl/req_gnt_timeout.sv
// req_gnt_timeout: loadable down-counter whose expire output pulses on the last enabled tick.
module req_gnt_timeout #(
  parameter int TICKS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(TICKS + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= CW'(TICKS);
    else if (en && cnt != '0) cnt <= cnt - CW'(1);
  end
  assign expire = en && cnt == CW'(1);
endmodule

// File: rtl/req_gnt_write_master.sv
// req_gnt_write_master: bursts a write stream onto a req/gnt bus, dropping out-of-range words.
// Define REQ_GNT_WRITE_MASTER_TIMEOUT_EN to give up on a grant after GNT_TIMEOUT cycles.
module req_gnt_write_master
  import req_gnt_pkg::*;
#(
  parameter int ADDR_MIN    = 1,
  parameter int ADDR_MAX    = 5,
  parameter int GNT_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [3:0]    len,
  input  logic [DW-1:0] wr_data_in,
  input  logic          wr_data_valid,
  output logic          wr_data_ready,
  output logic          req,
  input  logic          gnt,
  output logic          ce,
  output logic          wr,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data,
  output logic          busy,
  output logic          done,
  output logic          range_err,
  output logic          abort,
  output logic          timeout
);
  localparam logic [AW-1:0] LO   = AW'(ADDR_MIN);
  localparam logic [AW-1:0] SPAN = AW'(ADDR_MAX - ADDR_MIN);
  state_t state, next;
  logic [AW-1:0] cur_addr;
  logic [4:0] cnt;
  logic fire, in_range, lost, launch, tmo;
  assign wr_data_ready = state == DATA && gnt;
  assign busy = state != IDLE;
  assign fire = wr_data_valid && wr_data_ready;
  assign launch = state == IDLE && start;
  assign lost = (state == DATA || state == WRITE) && !gnt;
  // offset compare avoids a constant-true test when ADDR_MIN is 0
  assign in_range = (cur_addr - LO) <= SPAN;
`ifdef REQ_GNT_WRITE_MASTER_TIMEOUT_EN
  req_gnt_timeout #(.TICKS(GNT_TIMEOUT)) u_timeout (
    .clk(clk),
    .rst_n(rst_n),
    .load(launch),
    .en(state == REQ && !gnt),
    .expire(tmo)
  );
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? REQ : IDLE;
      REQ:     next = gnt ? DATA : tmo ? IDLE : REQ;
      DATA:    next = !gnt ? RELEASE : fire ? WRITE : DATA;
      WRITE:   next = (!gnt || cnt == 5'd1) ? RELEASE : DATA;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      cnt       <= '0;
      req       <= 1'b0;
      ce        <= 1'b0;
      wr        <= 1'b0;
      addr      <= '0;
      data      <= '0;
      done      <= 1'b0;
      range_err <= 1'b0;
      abort     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= next;
      cur_addr  <= launch ? start_addr : state == WRITE ? cur_addr + AW'(1) : cur_addr;
      cnt       <= launch ? {len == 4'd0, len} : state == WRITE ? cnt - 5'd1 : cnt;
      req       <= next == REQ || next == DATA || next == WRITE;
      ce        <= fire && in_range;
      wr        <= fire && in_range;
      addr      <= fire ? cur_addr : '0;
      data      <= fire ? wr_data_in : '0;
      done      <= next == RELEASE;
      range_err <= fire && !in_range;
      abort     <= lost;
      timeout   <= tmo;
    end
  end
endmodule

// File: tb/tb_req_gnt_write_master.sv
// tb_req_gnt_write_master: directed bursts against a default-range and a full-range instance.
module tb_req_gnt_write_master;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, wr_data_valid = 1'b0, gnt = 1'b0;
  logic [7:0] start_addr = '0, wr_data_in = '0;
  logic [3:0] len = '0;
  logic [1:0] rdy, req, ce, wr, busy, done, rerr, abrt, tmo;
  logic [7:0] addr [2];
  logic [7:0] data [2];
  int errors = 0, checks = 0, sel = 0;
  logic [7:0] wa[$], wd[$];
  logic [1:0] lcw[$];
  logic lre[$];
  int nw, first_w, last_w, done_cyc, aborted, abort_at_done, req_at_done, ended;

  always #5 clk = ~clk;

  req_gnt_write_master dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .len(len),
    .wr_data_in(wr_data_in), .wr_data_valid(wr_data_valid), .wr_data_ready(rdy[0]),
    .req(req[0]), .gnt(gnt), .ce(ce[0]), .wr(wr[0]), .addr(addr[0]), .data(data[0]),
    .busy(busy[0]), .done(done[0]), .range_err(rerr[0]), .abort(abrt[0]), .timeout(tmo[0])
  );

  req_gnt_write_master #(.ADDR_MIN(0), .ADDR_MAX(255), .GNT_TIMEOUT(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .len(len),
    .wr_data_in(wr_data_in), .wr_data_valid(wr_data_valid), .wr_data_ready(rdy[1]),
    .req(req[1]), .gnt(gnt), .ce(ce[1]), .wr(wr[1]), .addr(addr[1]), .data(data[1]),
    .busy(busy[1]), .done(done[1]), .range_err(rerr[1]), .abort(abrt[1]), .timeout(tmo[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic f;
    f = rdy[sel] && wr_data_valid;
    @(posedge clk);
    #1;
    if (f) wr_data_in = wr_data_in + 8'd1;
  endtask

  task automatic burst(input int s, input logic [7:0] a, input logic [3:0] l,
                       input logic [7:0] base, input int drop);
    sel = s;
    wa.delete(); wd.delete(); lcw.delete(); lre.delete();
    nw = 0; first_w = -1; last_w = -1; done_cyc = -1;
    aborted = 0; abort_at_done = 0; req_at_done = 1; ended = 0;
    wr_data_in = base; gnt = 1'b1; wr_data_valid = 1'b1;
    start = 1'b1; start_addr = a; len = l;
    step();
    start = 1'b0;
    for (int c = 1; c <= 60 && ended == 0; c++) begin
      step();
      if (ce[sel] || rerr[sel]) begin
        wa.push_back(addr[sel]); wd.push_back(data[sel]);
        lcw.push_back({ce[sel], wr[sel]}); lre.push_back(rerr[sel]);
        if (first_w < 0) first_w = c;
        last_w = c;
        nw++;
        if (drop != 0 && nw == drop) gnt = 1'b0;
      end
      if (done[sel]) begin
        done_cyc = c; req_at_done = req[sel]; abort_at_done = abrt[sel];
      end
      if (abrt[sel]) aborted++;
      if (!busy[sel]) ended = 1;
    end
    chk("burst_ends", ended, 1);
    gnt = 1'b1;
  endtask

  initial begin
    step(); step();
    chk("rst_req", req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ce_wr", {ce, wr}, 0);
    chk("rst_addr_data", {addr[0], data[0], addr[1], data[1]}, 0);
    chk("rst_pulses", {done, rerr, abrt, tmo}, 0);
    rst_n = 1'b1;
    step();

    burst(0, 8'h01, 4'd3, 8'hA0, 0);
    chk("b1_count", nw, 3);
    chk("b1_addrs", {wa[0], wa[1], wa[2]}, 24'h010203);
    chk("b1_data", {wd[0], wd[1], wd[2]}, 24'hA0A1A2);
    chk("b1_cewr", {lcw[0], lcw[1], lcw[2]}, 6'b111111);
    chk("b1_first_write", first_w, 2);
    chk("b1_last_write", last_w, 6);
    chk("b1_done_cyc", done_cyc, 7);
    chk("b1_req_at_done", req_at_done, 0);
    chk("b1_no_abort", aborted, 0);
    chk("b1_req_after", req[0], 0);

    burst(0, 8'h04, 4'd3, 8'hB0, 0);
    chk("b2_addrs", {wa[0], wa[1], wa[2]}, 24'h040506);
    chk("b2_cewr", {lcw[0], lcw[1], lcw[2]}, 6'b111100);
    chk("b2_range_err", {lre[0], lre[1], lre[2]}, 3'b001);
    chk("b2_done_cyc", done_cyc, 7);

    burst(1, 8'hFE, 4'd3, 8'hC0, 0);
    chk("wrap_addrs", {wa[0], wa[1], wa[2]}, 24'hFEFF00);
    chk("wrap_cewr", {lcw[0], lcw[1], lcw[2]}, 6'b111111);
    chk("wrap_no_err", {lre[0], lre[1], lre[2]}, 3'b000);

    burst(1, 8'h00, 4'd0, 8'h00, 0);
    chk("len16_count", nw, 16);
    chk("len16_last", {wa[15], wd[15]}, 16'h0F0F);
    chk("len16_done_cyc", done_cyc, 33);

    burst(0, 8'h01, 4'd0, 8'hD0, 2);
    chk("abort_count", nw, 2);
    chk("abort_second", {wa[1], wd[1]}, 16'h02D1);
    chk("abort_pulses", aborted, 1);
    chk("abort_with_done", abort_at_done, 1);
    chk("abort_done_cyc", done_cyc, 5);

    sel = 0; wr_data_valid = 1'b0; gnt = 1'b1;
    start = 1'b1; start_addr = 8'h01; len = 4'd3;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("stall_hold", {req[0], busy[0], ce[0], rdy[0]}, 4'b1101);
    rst_n = 1'b0;
    step();
    chk("midrst_outs", {req[0], ce[0], wr[0], done[0], rerr[0], abrt[0], tmo[0], busy[0], rdy[0]}, 0);
    chk("midrst_bus", {addr[0], data[0]}, 0);
    rst_n = 1'b1;
    step();
    chk("midrst_idle", busy[0], 0);

    wr_data_valid = 1'b1; wr_data_in = 8'h5A;
    start = 1'b1; start_addr = 8'h01; len = 4'd1;
    step();
    start_addr = 8'h04; len = 4'd2;
    step();
    start = 1'b0;
    step();
    chk("busy_start_write", {ce[0], addr[0], data[0]}, {1'b1, 8'h01, 8'h5A});
    step();
    chk("busy_start_done", done[0], 1);
    step(); step();
    chk("busy_start_ignored", {busy[0], ce[0]}, 0);

    sel = 1; gnt = 1'b0;
    start = 1'b1; start_addr = 8'h01; len = 4'd1;
    step();
    start = 1'b0;
    chk("tmo_req", req[1], 1);
    for (int i = 1; i <= 15; i++) step();
    chk("tmo_before", {req[1], tmo[1], busy[1]}, 3'b101);
    step();
`ifdef REQ_GNT_WRITE_MASTER_TIMEOUT_EN
    chk("tmo_pulse", {req[1], tmo[1], busy[1], done[1]}, 4'b0100);
    step();
    chk("tmo_after", {tmo[1], done[1], busy[1]}, 3'b000);
`else
    chk("tmo_wait", {req[1], tmo[1], busy[1]}, 3'b101);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("tmo_reset_exit", busy[1], 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/req_gnt_write_master.md
REQ_GNT_WRITE_MASTER -- requirements
Module: req_gnt_write_master

Interface
REQ-001 Parameter ADDR_MIN, default 1: lowest legal write address, inclusive.
REQ-002 Parameter ADDR_MAX, default 5: highest legal write address, inclusive; ADDR_MIN <= ADDR_MAX.
REQ-003 Parameter GNT_TIMEOUT, default 16: maximum cycles in REQ waiting for gnt; used only with timeout compiled in.
REQ-004 Ports, one per line, clock and reset first:
  clk  in  1  single clock, all logic on its posedge
  rst_n  in  1  synchronous, active-low reset
  start  in  1  one-cycle burst request pulse
  start_addr  in  8  first burst address
  len  in  4  burst word count; 0 means 16
  wr_data_in  in  8  write data stream
  wr_data_valid  in  1  stream valid
  wr_data_ready  out  1  stream ready
  req  out  1  bus request
  gnt  in  1  bus grant
  ce  out  1  chip enable
  wr  out  1  write strobe
  addr  out  8  write address
  data  out  8  write data
  busy  out  1  high whenever state != IDLE
  done  out  1  one-cycle burst-complete pulse
  range_err  out  1  one-cycle pulse: a word was dropped as out of range
  abort  out  1  one-cycle pulse: gnt lost mid-burst
  timeout  out  1  one-cycle pulse: gnt never arrived

Function
REQ-005 The FSM SHALL have states IDLE, REQ, DATA, WRITE, RELEASE; all outputs except wr_data_ready and busy are registered.
REQ-006 IDLE: start=1 SHALL latch start_addr and len, and enter REQ. req=1 in the next cycle.
REQ-007 start SHALL be ignored whenever state != IDLE.
REQ-008 REQ: req=1. gnt sampled high SHALL move to DATA.
REQ-009 DATA: wr_data_ready=gnt. On wr_data_valid&&wr_data_ready, the FSM SHALL enter WRITE with addr and data registered.
REQ-010 WRITE: exactly one cycle.
  - Current address in [ADDR_MIN,ADDR_MAX]: ce=wr=1.
  - Otherwise: ce=wr=0 and range_err=1.
  - Then the address increments modulo 256 (0xFF wraps to 0x00) and the word count decrements.
REQ-011 After WRITE, the FSM SHALL go to DATA if words remain, else to RELEASE.
REQ-012 Outside WRITE: ce=wr=0, addr=0, data=0.
REQ-013 RELEASE: req=0, done=1 for one cycle, then IDLE.
REQ-014 gnt=0 sampled in DATA or WRITE SHALL:
  - complete any WRITE cycle already in progress;
  - pulse abort;
  - enter RELEASE, which still pulses done.
REQ-015 wr_data_valid held low in DATA SHALL stall indefinitely with req held high.
REQ-016 Latency: start at cycle N, gnt already high → first WRITE no earlier than N+3; back-to-back words every 2 cycles.

Reset
REQ-017 rst_n=0 at a clock edge SHALL force IDLE from any state, including mid-burst.
REQ-018 Under reset, all registered outputs SHALL be 0, and the latched address and count SHALL be cleared; no done or abort pulse is generated.

Configuration
REQ-019 Macro REQ_GNT_WRITE_MASTER_TIMEOUT_EN is the only compile option.
  - Defined: a counter runs in REQ. After GNT_TIMEOUT cycles without gnt, the FSM SHALL pulse timeout, drop req and return to IDLE without done.
  - Undefined: REQ waits indefinitely, timeout is tied to 0, and GNT_TIMEOUT is unused.

Structure
REQ-020 Shared package req_gnt_pkg SHALL hold the FSM state enum and the address-width and data-width constants (8).
REQ-021 Sub-module req_gnt_timeout (loadable down-counter with expiry pulse) SHALL be instantiated only under REQ_GNT_WRITE_MASTER_TIMEOUT_EN.

Verification
REQ-022 Burst, all in range:
  - Stimulus: start_addr=1, len=3, gnt tied 1, valid tied 1, data 0xA0..0xA2.
  - Response: three ce=wr=1 cycles at addr 1,2,3 with those data values; then done; req low after done.
REQ-023 Range drop:
  - Stimulus: start_addr=4, len=3.
  - Response: writes at 4 and 5; word for address 6 dropped with range_err=1, ce=0; done.
REQ-024 Wrap:
  - Stimulus: ADDR_MIN=0, ADDR_MAX=255, start_addr=0xFE, len=3.
  - Response: addr 0xFE, 0xFF, 0x00.
REQ-025 Abort:
  - Stimulus: len=0 (16 words); gnt dropped after the 2nd write.
  - Response: no 3rd write; abort then done; busy falls.
REQ-026 Reset mid-burst:
  - Stimulus: rst_n=0 for 1 cycle during DATA; then start while busy.
  - Response: all outputs 0 the next cycle; a start issued while busy is ignored.
REQ-027 With macro defined:
  - Stimulus: GNT_TIMEOUT=16, gnt held 0.
  - Response: timeout pulse after 16 REQ cycles, req low, no done.
